mac_dot_product: RTL and testbench

- Parametrised successor to the team's single-lane multiply-accumulate block.
- Computes a fixed-length dot product of VEC_LEN operand pairs streamed in over a valid/ready handshake.
- Presents a saturated ACC_WIDTH result with a sticky overflow flag over an output valid/ready handshake, then re-arms automatically.
- Sits between a sample source (FIFO or DMA stream) and a result consumer in the datapath.

---
 rtl/mac_pkg.sv | 25 ++
 rtl/mac_sat_add.sv | 41 ++++
 rtl/mac_dot_product.sv | 124 ++++++++++++
 tb/tb_mac_dot_product.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared types and helpers for the dot-product MAC.
// State encoding, counter sizing and saturation limits.
package mac_pkg;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Limits are returned in 64 bits; callers keep the low ACC_WIDTH bits.
    function automatic logic [63:0] sat_max(input int w, input int sgn);
        return (sgn != 0) ? (64'd1 << (w - 1)) - 64'd1
                          : (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w, input int sgn);
        return (sgn != 0) ? ~((64'd1 << (w - 1)) - 64'd1) : 64'd0;
    endfunction

endpackage

// File: rtl/mac_sat_add.sv
// mac_sat_add: accumulator plus extended product, clamped to ACC_WIDTH.
// Purely combinational; reports whether a clamp was applied.
module mac_sat_add
    import mac_pkg::*;
#(
    parameter int ACC_WIDTH = 24,
    parameter int SIGNED    = 0
)(
    input  logic [ACC_WIDTH-1:0] i_acc,
    input  logic [ACC_WIDTH:0]   i_term,
    output logic [ACC_WIDTH-1:0] o_sum,
    output logic                 o_ovf
);

    localparam logic [63:0] MAX64 = sat_max(ACC_WIDTH, SIGNED);
    localparam logic [63:0] MIN64 = sat_min(ACC_WIDTH, SIGNED);
    localparam logic [ACC_WIDTH-1:0] SAT_MAX = MAX64[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0] SAT_MIN = MIN64[ACC_WIDTH-1:0];

    logic                 w_ext;
    logic [ACC_WIDTH:0]   w_sum;

    assign w_ext = (SIGNED != 0) && i_acc[ACC_WIDTH-1];
    assign w_sum = {w_ext, i_acc} + i_term;

    always_comb begin
        o_sum = w_sum[ACC_WIDTH-1:0];
        o_ovf = 1'b0;
        if (SIGNED != 0) begin
            // Top two bits disagree: the signed sum left the ACC_WIDTH range.
            if (w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1]) begin
                o_ovf = 1'b1;
                o_sum = w_sum[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
            end
        end else if (w_sum[ACC_WIDTH]) begin
            o_ovf = 1'b1;
            o_sum = SAT_MAX;
        end
    end

endmodule

// File: rtl/mac_dot_product.sv
// mac_dot_product: streamed VEC_LEN-pair dot product with saturation.
// Two-stage pipeline (operand register, saturating accumulate) plus FSM.
module mac_dot_product
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int VEC_LEN    = 16,
    parameter int SIGNED     = 0
)(
    input  logic                  clk,
    input  logic                  s_reset_n,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  overflow
);

    localparam int CW = cnt_width(VEC_LEN);
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic                  r_s1_valid;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_ovf;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [ACC_WIDTH-1:0]  r_acc;

    logic                  w_in_fire;
    logic                  w_out_fire;
    logic [PW-1:0]         w_a_x;
    logic [PW-1:0]         w_b_x;
    logic [PW-1:0]         w_prod;
    logic [ACC_WIDTH:0]    w_term;
    logic [ACC_WIDTH-1:0]  w_sum;
    logic                  w_ovf;

    assign w_in_fire  = in_valid && r_in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    // Extending first makes the low PW bits the exact product in both modes.
    assign w_a_x  = {{DATA_WIDTH{(SIGNED != 0) && r_a[DATA_WIDTH-1]}}, r_a};
    assign w_b_x  = {{DATA_WIDTH{(SIGNED != 0) && r_b[DATA_WIDTH-1]}}, r_b};
    assign w_prod = w_a_x * w_b_x;
    assign w_term = {{(ACC_WIDTH + 1 - PW){(SIGNED != 0) && w_prod[PW-1]}},
                     w_prod};

    mac_sat_add #(
        .ACC_WIDTH (ACC_WIDTH),
        .SIGNED    (SIGNED)
    ) u_sat_add (
        .i_acc  (r_acc),
        .i_term (w_term),
        .o_sum  (w_sum),
        .o_ovf  (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (!s_reset_n || clear) begin
            r_state     <= ST_ACC;
            r_cnt       <= '0;
            r_s1_valid  <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_in_fire;
            if (w_in_fire) begin
                r_a <= op_a;
                r_b <= op_b;
            end
            if (r_s1_valid) begin
                r_acc <= w_sum;
                r_ovf <= r_ovf | w_ovf;
            end
            unique case (r_state)
                ST_ACC: begin
                    if (w_in_fire) begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == LAST) begin
                            r_state    <= ST_DRAIN;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!r_s1_valid) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (w_out_fire) begin
                        r_state     <= ST_ACC;
                        r_cnt       <= '0;
                        r_acc       <= '0;
                        r_ovf       <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: r_state <= ST_ACC;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_acc;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_mac_dot_product.sv
// tb_mac_dot_product: directed checks on three configurations of the MAC.
// Expected results come from a reference model pushed to a scoreboard.
module tb_mac_dot_product;

    logic       clk = 1'b0;
    logic       s_reset_n;
    logic       clear;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] op_a;
    logic [7:0] op_b;
    int         sel;

    logic        iv0, iv1, iv2;
    logic        rdy0, rdy1, rdy2;
    logic        ov0, ov1, ov2;
    logic        of0, of1, of2;
    logic [23:0] res0, res1;
    logic [15:0] res2;

    logic        w_rdy, w_ov, w_of;
    logic [23:0] w_res;

    int P_SG [3] = '{0, 1, 0};
    int P_AW [3] = '{24, 24, 16};

    int          n_run  = 0;
    int          n_fail = 0;
    longint      m_acc;
    bit          m_ovf;
    logic [24:0] sb [$];

    always #5 clk = ~clk;

    assign iv0 = in_valid && (sel == 0);
    assign iv1 = in_valid && (sel == 1);
    assign iv2 = in_valid && (sel == 2);

    mac_dot_product #(.DATA_WIDTH(8), .ACC_WIDTH(24), .VEC_LEN(4), .SIGNED(0))
    u_dut0 (
        .clk(clk), .s_reset_n(s_reset_n), .clear(clear),
        .in_valid(iv0), .in_ready(rdy0), .op_a(op_a), .op_b(op_b),
        .out_valid(ov0), .out_ready(out_ready),
        .result(res0), .overflow(of0)
    );

    mac_dot_product #(.DATA_WIDTH(8), .ACC_WIDTH(24), .VEC_LEN(4), .SIGNED(1))
    u_dut1 (
        .clk(clk), .s_reset_n(s_reset_n), .clear(clear),
        .in_valid(iv1), .in_ready(rdy1), .op_a(op_a), .op_b(op_b),
        .out_valid(ov1), .out_ready(out_ready),
        .result(res1), .overflow(of1)
    );

    mac_dot_product #(.DATA_WIDTH(8), .ACC_WIDTH(16), .VEC_LEN(2), .SIGNED(0))
    u_dut2 (
        .clk(clk), .s_reset_n(s_reset_n), .clear(clear),
        .in_valid(iv2), .in_ready(rdy2), .op_a(op_a), .op_b(op_b),
        .out_valid(ov2), .out_ready(out_ready),
        .result(res2), .overflow(of2)
    );

    always_comb begin
        w_rdy = rdy0;
        w_ov  = ov0;
        w_of  = of0;
        w_res = res0;
        case (sel)
            1: begin
                w_rdy = rdy1; w_ov = ov1; w_of = of1; w_res = res1;
            end
            2: begin
                w_rdy = rdy2; w_ov = ov2; w_of = of2; w_res = {8'd0, res2};
            end
            default: ;
        endcase
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_model();
        m_acc = 0;
        m_ovf = 1'b0;
    endtask

    task automatic model_step(int a, int b);
        longint p, s, mx, mn;
        p = longint'(a) * longint'(b);
        s = m_acc + p;
        if (P_SG[sel] != 0) begin
            mx = (longint'(1) << (P_AW[sel] - 1)) - 1;
            mn = -mx - 1;
        end else begin
            mx = (longint'(1) << P_AW[sel]) - 1;
            mn = 0;
        end
        if (s > mx) begin
            s = mx; m_ovf = 1'b1;
        end else if (s < mn) begin
            s = mn; m_ovf = 1'b1;
        end
        m_acc = s;
    endtask

    task automatic finish_vec();
        longint msk;
        logic [23:0] er;
        msk = (longint'(1) << P_AW[sel]) - 1;
        er  = 24'(m_acc & msk);
        sb.push_back({m_ovf, er});
        clr_model();
    endtask

    // Holds the pair until accepted; in_valid stays high for back-to-back use.
    task automatic send_pair(int a, int b);
        int w;
        logic [31:0] av, bv;
        av = a;
        bv = b;
        w = 0;
        in_valid = 1'b1;
        op_a = av[7:0];
        op_b = bv[7:0];
        while (!w_rdy && w < 30) begin
            step();
            w++;
        end
        if (!w_rdy) begin
            n_run++;
            n_fail++;
            $display("FAIL in_ready_wait observed=0 expected=1");
        end else begin
            step();
            model_step(a, b);
        end
    endtask

    task automatic wait_ov();
        int w;
        w = 0;
        while (!w_ov && w < 40) begin
            step();
            w++;
        end
        chk("out_valid_wait", 32'(w_ov), 32'd1);
    endtask

    task automatic expect_out(string tag);
        logic [24:0] e;
        wait_ov();
        if (w_ov) begin
            if (sb.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL %s_sb_empty observed=0 expected=1", tag);
            end else begin
                e = sb.pop_front();
                chk({tag, "_result"}, 32'(w_res), 32'(e[23:0]));
                chk({tag, "_ovf"}, 32'(w_of), 32'(e[24]));
                out_ready = 1'b1;
                step();
                chk({tag, "_ov_drop"}, 32'(w_ov), 32'd0);
                chk({tag, "_rearm"}, 32'(w_rdy), 32'd1);
            end
        end
    endtask

    initial begin
        s_reset_n = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_a      = '0;
        op_b      = '0;
        sel       = 0;
        clr_model();

        step();
        step();
        chk("rst_out_valid", 32'(w_ov), 32'd0);
        chk("rst_result", 32'(w_res), 32'd0);
        chk("rst_overflow", 32'(w_of), 32'd0);
        chk("rst_in_ready", 32'(w_rdy), 32'd1);
        s_reset_n = 1'b1;
        step();

        // Unsigned back-to-back vector with latency probes.
        sel = 0;
        send_pair(1, 2);
        send_pair(3, 4);
        send_pair(5, 6);
        send_pair(7, 8);
        in_valid = 1'b0;
        finish_vec();
        chk("t1_drain_in_ready", 32'(w_rdy), 32'd0);
        chk("t1_ov_edge0", 32'(w_ov), 32'd0);
        step();
        chk("t1_ov_edge1", 32'(w_ov), 32'd0);
        chk("t1_in_ready_e1", 32'(w_rdy), 32'd0);
        step();
        chk("t1_ov_edge2", 32'(w_ov), 32'd1);
        chk("t1_done_in_ready", 32'(w_rdy), 32'd0);
        chk("t1_result_100", 32'(w_res), 32'd100);
        expect_out("t1");

        // Signed vector.
        sel = 1;
        send_pair(-128, 127);
        send_pair(-1, -1);
        send_pair(2, -3);
        send_pair(10, 10);
        in_valid = 1'b0;
        finish_vec();
        expect_out("t2");

        // Saturation, then a clean vector to confirm overflow is not carried.
        sel = 2;
        send_pair(255, 255);
        send_pair(255, 255);
        in_valid = 1'b0;
        finish_vec();
        wait_ov();
        chk("t3_sat_value", 32'(w_res), 32'hFFFF);
        chk("t3_sat_flag", 32'(w_of), 32'd1);
        expect_out("t3a");
        send_pair(1, 1);
        send_pair(1, 1);
        in_valid = 1'b0;
        finish_vec();
        expect_out("t3b");

        // Output backpressure with ignored input pulses.
        sel = 0;
        out_ready = 1'b0;
        send_pair(9, 9);
        send_pair(2, 8);
        send_pair(0, 200);
        send_pair(255, 3);
        in_valid = 1'b0;
        finish_vec();
        wait_ov();
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            op_a = 8'hAA;
            op_b = 8'h55;
            step();
            chk("t4_hold_ov", 32'(w_ov), 32'd1);
            chk("t4_hold_result", 32'(w_res), 32'(sb[0][23:0]));
            chk("t4_hold_in_ready", 32'(w_rdy), 32'd0);
        end
        in_valid = 1'b0;
        expect_out("t4");

        // Clear drops the pair presented with it and restarts the vector.
        send_pair(5, 5);
        send_pair(5, 5);
        op_a = 8'd9;
        op_b = 8'd9;
        clear = 1'b1;
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        clr_model();
        chk("t5_clr_result", 32'(w_res), 32'd0);
        chk("t5_clr_in_ready", 32'(w_rdy), 32'd1);
        chk("t5_clr_ov", 32'(w_ov), 32'd0);
        for (int i = 0; i < 4; i++) send_pair(1, 1);
        in_valid = 1'b0;
        finish_vec();
        expect_out("t5");

        // Reset while holding a saturated result in DONE.
        sel = 2;
        out_ready = 1'b0;
        send_pair(255, 255);
        send_pair(255, 255);
        in_valid = 1'b0;
        clr_model();
        wait_ov();
        chk("t6_pre_ovf", 32'(w_of), 32'd1);
        s_reset_n = 1'b0;
        step();
        s_reset_n = 1'b1;
        chk("t6_rst_ov", 32'(w_ov), 32'd0);
        chk("t6_rst_result", 32'(w_res), 32'd0);
        chk("t6_rst_ovf", 32'(w_of), 32'd0);
        chk("t6_rst_in_ready", 32'(w_rdy), 32'd1);

        // Reset in mid-ACC, then a full vector to confirm recovery.
        sel = 0;
        out_ready = 1'b1;
        send_pair(7, 7);
        send_pair(7, 7);
        in_valid = 1'b0;
        step();
        s_reset_n = 1'b0;
        step();
        s_reset_n = 1'b1;
        clr_model();
        chk("t7_rst_result", 32'(w_res), 32'd0);
        chk("t7_rst_in_ready", 32'(w_rdy), 32'd1);
        step();
        chk("t7_in_ready_next", 32'(w_rdy), 32'd1);
        for (int i = 0; i < 4; i++) send_pair(2, 3);
        in_valid = 1'b0;
        finish_vec();
        expect_out("t7");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
